spectrum_frame_ctrl: RTL and testbench

Frame sequencer between the ADC sample FIFO, the FFT core and the VGA display. It waits for a full frame of samples, streams it into the FFT, and converts each output bin to a scaled, saturated squared magnitude. Magnitudes are written into an internal ping-pong spectrum buffer, so the display always reads a complete, stable frame. An optional peak-hold/decay mode is available.

---
 rtl/spectrum_frame_ctrl_if.sv | 39 +++
 rtl/spectrum_frame_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_spectrum_frame_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_frame_ctrl_if.sv
// Spectrum frame controller bus: sample FIFO, FFT core, display port and status.
// master = frame controller side, slave = surrounding system side.
interface spectrum_frame_ctrl_if #(
    parameter int SAMPLE_W   = 8,
    parameter int LOG2_N     = 9,
    parameter int FIFO_CNT_W = 11,
    parameter int MAG_W      = 8
) ();
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [SAMPLE_W-1:0]   fifo_dout;
    logic                  fifo_rd_en;
    logic                  fft_start;
    logic [SAMPLE_W-1:0]   fft_xn_re;
    logic                  fft_xn_valid;
    logic                  fft_dv;
    logic [LOG2_N-1:0]     fft_xk_index;
    logic [SAMPLE_W-1:0]   fft_xk_re;
    logic [SAMPLE_W-1:0]   fft_xk_im;
    logic [LOG2_N-1:0]     disp_addr;
    logic [MAG_W-1:0]      disp_data;
    logic                  peak_en;
    logic                  busy;
    logic                  frame_ready;
    logic [15:0]           frame_cnt;

    modport master (
        input  fifo_count, fifo_dout, fft_dv, fft_xk_index, fft_xk_re, fft_xk_im,
               disp_addr, peak_en,
        output fifo_rd_en, fft_start, fft_xn_re, fft_xn_valid, disp_data, busy,
               frame_ready, frame_cnt
    );

    modport slave (
        output fifo_count, fifo_dout, fft_dv, fft_xk_index, fft_xk_re, fft_xk_im,
               disp_addr, peak_en,
        input  fifo_rd_en, fft_start, fft_xn_re, fft_xn_valid, disp_data, busy,
               frame_ready, frame_cnt
    );
endinterface

// File: rtl/spectrum_frame_ctrl.sv
// Frame sequencer: waits for a full FIFO frame, streams it to the FFT, turns
// FFT bins into saturated squared magnitudes in a ping-pong spectrum buffer,
// with optional peak-hold/decay. The display always reads the front bank.
module spectrum_frame_ctrl #(
    parameter int SAMPLE_W   = 8,
    parameter int LOG2_N     = 9,
    parameter int FIFO_CNT_W = 11,
    parameter int MAG_W      = 8,
    parameter int MAG_SHIFT  = 4,
    parameter int DECAY      = 1
) (
    input  logic                 cclk,
    input  logic                 reset,
    spectrum_frame_ctrl_if.master bus
);
    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = 2 * SAMPLE_W + 1;
    localparam int SQ_W  = 2 * SAMPLE_W;

    typedef enum logic [2:0] {CLEAR, WAIT_FILL, LOAD, COMPUTE, SWAP} state_t;

    state_t              state;
    logic [LOG2_N-1:0]   clr_idx;
    logic [LOG2_N-1:0]   rd_cnt;
    logic [LOG2_N:0]     acc_cnt;
    logic                fifo_rd_en;
    logic                fft_start;
    logic                busy;
    logic                frame_ready;
    logic [15:0]         frame_cnt;
    logic                peak_mode;
    logic                front_sel;
    logic                fft_xn_valid;
    logic [SAMPLE_W-1:0] fft_xn_re;
    logic [MAG_W-1:0]    disp_data;

    logic [MAG_W-1:0]    bank0 [N];
    logic [MAG_W-1:0]    bank1 [N];

    logic                       acc_done;
    logic                       dv_ok;
    logic signed [SAMPLE_W-1:0] xk_re_s;
    logic signed [SAMPLE_W-1:0] xk_im_s;
    logic                       vld_p0;
    logic                       vld_p1;
    logic signed [SQ_W-1:0]     sq_re_p0;
    logic signed [SQ_W-1:0]     sq_im_p0;
    logic [LOG2_N-1:0]          idx_p0;
    logic [LOG2_N-1:0]          idx_p1;
    logic signed [SUM_W-1:0]    sum_p0;
    logic [MAG_W-1:0]           front_rd;
    logic [MAG_W-1:0]           val_p1;

    // Shift the non-negative sum down and clamp to the stored magnitude width.
    function automatic logic [MAG_W-1:0] sat_mag(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] sh;
        sh = sum >>> MAG_SHIFT;
        if (sh[SUM_W-1:MAG_W] != '0)
            return '1;
        return sh[MAG_W-1:0];
    endfunction

    // Peak hold: the previous frame's value decays by DECAY (floored at 0) unless beaten.
    function automatic logic [MAG_W-1:0] peak_hold(input logic [MAG_W-1:0] mag,
                                                   input logic [MAG_W-1:0] front);
        logic [MAG_W-1:0] dec;
        dec = (front >= MAG_W'(DECAY)) ? front - MAG_W'(DECAY) : '0;
        return (mag > dec) ? mag : dec;
    endfunction

    assign acc_done = (acc_cnt == (LOG2_N + 1)'(N));
    assign dv_ok    = (state == COMPUTE) && bus.fft_dv && !acc_done;
    assign xk_re_s  = bus.fft_xk_re;
    assign xk_im_s  = bus.fft_xk_im;

    // Frame sequencing FSM with registered control outputs.
    always_ff @(posedge cclk) begin
        if (reset) begin
            state       <= CLEAR;
            clr_idx     <= '0;
            rd_cnt      <= '0;
            acc_cnt     <= '0;
            fifo_rd_en  <= 1'b0;
            fft_start   <= 1'b0;
            busy        <= 1'b1;
            frame_ready <= 1'b0;
            frame_cnt   <= '0;
            peak_mode   <= 1'b0;
            front_sel   <= 1'b0;
        end else begin
            fft_start   <= 1'b0;
            frame_ready <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + LOG2_N'(1);
                    if (clr_idx == LOG2_N'(N - 1)) begin
                        state <= WAIT_FILL;
                        busy  <= 1'b0;
                    end
                end
                WAIT_FILL: begin
                    if (bus.fifo_count >= FIFO_CNT_W'(N)) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        fft_start  <= 1'b1;
                        fifo_rd_en <= 1'b1;
                        peak_mode  <= bus.peak_en;
                        rd_cnt     <= '0;
                        acc_cnt    <= '0;
                    end
                end
                LOAD: begin
                    // Read strobe stays high for exactly N cycles; the cycle after
                    // it drops carries the last forwarded sample.
                    if (fifo_rd_en) begin
                        rd_cnt <= rd_cnt + LOG2_N'(1);
                        if (rd_cnt == LOG2_N'(N - 1))
                            fifo_rd_en <= 1'b0;
                    end else begin
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (dv_ok)
                        acc_cnt <= acc_cnt + (LOG2_N + 1)'(1);
                    // All beats accepted and the final one is being written now.
                    if (acc_done && vld_p1 && !vld_p0)
                        state <= SWAP;
                end
                SWAP: begin
                    state       <= WAIT_FILL;
                    busy        <= 1'b0;
                    front_sel   <= ~front_sel;
                    frame_ready <= 1'b1;
                    frame_cnt   <= frame_cnt + 16'd1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Forward each FIFO word to the FFT one cycle after its read strobe.
    always_ff @(posedge cclk) begin
        if (reset) begin
            fft_xn_valid <= 1'b0;
            fft_xn_re    <= '0;
        end else begin
            fft_xn_valid <= fifo_rd_en;
            fft_xn_re    <= bus.fifo_dout;
        end
    end

    // Magnitude pipeline valids; cleared on reset so in-flight writes are dropped.
    always_ff @(posedge cclk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= dv_ok;
            vld_p1 <= vld_p0;
        end
    end

    assign sum_p0   = SUM_W'(sq_re_p0) + SUM_W'(sq_im_p0);
    assign front_rd = front_sel ? bank1[idx_p0] : bank0[idx_p0];

    // Magnitude pipeline data: p0 = squares, p1 = saturated/peak-held value.
    always_ff @(posedge cclk) begin
        // p0: square both components
        sq_re_p0 <= SQ_W'(xk_re_s) * SQ_W'(xk_re_s);
        sq_im_p0 <= SQ_W'(xk_im_s) * SQ_W'(xk_im_s);
        idx_p0   <= bus.fft_xk_index;
        // p1: sum, shift, saturate, merge with decayed front value
        idx_p1   <= idx_p0;
        val_p1   <= peak_mode ? peak_hold(sat_mag(sum_p0), front_rd) : sat_mag(sum_p0);
    end

    // Bank writes: zero both banks during CLEAR, otherwise fill the back bank.
    always_ff @(posedge cclk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                bank0[clr_idx] <= '0;
                bank1[clr_idx] <= '0;
            end else if (vld_p1) begin
                if (front_sel)
                    bank0[idx_p1] <= val_p1;
                else
                    bank1[idx_p1] <= val_p1;
            end
        end
    end

    // Registered display read from the front bank.
    always_ff @(posedge cclk) begin
        if (reset)
            disp_data <= '0;
        else
            disp_data <= front_sel ? bank1[bus.disp_addr] : bank0[bus.disp_addr];
    end

    assign bus.fifo_rd_en   = fifo_rd_en;
    assign bus.fft_start    = fft_start;
    assign bus.fft_xn_re    = fft_xn_re;
    assign bus.fft_xn_valid = fft_xn_valid;
    assign bus.disp_data    = disp_data;
    assign bus.busy         = busy;
    assign bus.frame_ready  = frame_ready;
    assign bus.frame_cnt    = frame_cnt;
endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Bench for spectrum_frame_ctrl: directed frames, scoreboard queues checked by a
// negedge monitor for forwarded samples, display reads and frame_ready events.
module tb_spectrum_frame_ctrl;
    localparam int SAMPLE_W   = 8;
    localparam int LOG2_N     = 9;
    localparam int FIFO_CNT_W = 11;
    localparam int MAG_W      = 8;
    localparam int N          = 512;

    logic cclk  = 1'b0;
    logic reset = 1'b1;
    always #5 cclk = ~cclk;

    spectrum_frame_ctrl_if #(.SAMPLE_W(SAMPLE_W), .LOG2_N(LOG2_N),
                             .FIFO_CNT_W(FIFO_CNT_W), .MAG_W(MAG_W)) bus ();

    spectrum_frame_ctrl #(.SAMPLE_W(SAMPLE_W), .LOG2_N(LOG2_N), .FIFO_CNT_W(FIFO_CNT_W),
                          .MAG_W(MAG_W), .MAG_SHIFT(4), .DECAY(1)) dut (
        .cclk  (cclk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  xn_q [$];
    logic [7:0]  rd_q [$];
    logic [15:0] fr_q [$];

    int   rd_total  = 0;
    int   start_cnt = 0;
    logic rd_req    = 1'b0;
    logic rd_vld_d  = 1'b0;

    logic [7:0]        exp_disp [N];
    logic signed [7:0] bre [N];
    logic signed [7:0] bim [N];

    function automatic logic [7:0] fifo_word(input int n);
        return 8'(n * 37 + 11);
    endfunction

    // First-word-fall-through FIFO model: word n is presented until popped.
    assign bus.fifo_dout = fifo_word(rd_total);

    always @(posedge cclk) begin
        if (bus.fifo_rd_en) rd_total <= rd_total + 1;
        if (bus.fft_start) start_cnt <= start_cnt + 1;
        rd_vld_d <= rd_req;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        forever begin
            @(negedge cclk);
            if (bus.fft_xn_valid) begin
                if (xn_q.size() == 0) check("xn_unexpected", 1, 0);
                else check("xn_re", int'(bus.fft_xn_re), int'(xn_q.pop_front()));
            end
            if (rd_vld_d) begin
                if (rd_q.size() == 0) check("disp_unexpected", 1, 0);
                else check("disp_data", int'(bus.disp_data), int'(rd_q.pop_front()));
            end
            if (bus.frame_ready) begin
                if (fr_q.size() == 0) check("frame_ready_unexpected", 1, 0);
                else check("frame_cnt_at_ready", int'(bus.frame_cnt), int'(fr_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic clear_bins();
        for (int k = 0; k < N; k++) begin
            bre[k] = '0;
            bim[k] = '0;
            exp_disp[k] = '0;
        end
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 2000);
        check("clear_cycles", n, N);
    endtask

    task automatic read_all();
        for (int a = 0; a < N; a++) begin
            bus.disp_addr = LOG2_N'(a);
            rd_req = 1'b1;
            rd_q.push_back(exp_disp[a]);
            tick();
        end
        rd_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic start_frame(output int rd0);
        int n;
        rd0 = rd_total;
        for (int k = 0; k < N; k++) xn_q.push_back(fifo_word(rd0 + k));
        bus.fifo_count = FIFO_CNT_W'(N);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.fft_start && n < 50);
        check("fft_start_seen", int'(bus.fft_start), 1);
        check("rd_en_with_start", int'(bus.fifo_rd_en), 1);
        bus.fifo_count = '0;
    endtask

    task automatic wait_load(input int rd0);
        int n;
        n = 0;
        while (bus.fifo_rd_en && n < 700) begin
            tick();
            n++;
        end
        check("rd_en_cycles", rd_total - rd0, N);
        tick();
    endtask

    task automatic pulse_dv(input int idx, input int re, input int im);
        bus.fft_dv       = 1'b1;
        bus.fft_xk_index = LOG2_N'(idx);
        bus.fft_xk_re    = 8'(re);
        bus.fft_xk_im    = 8'(im);
        repeat (3) tick();
        bus.fft_dv = 1'b0;
    endtask

    task automatic send_beats(input bit gap, input int prev_cnt);
        for (int k = 0; k < N; k++) begin
            if (gap && k == N - 1) begin
                bus.fft_dv = 1'b0;
                repeat (10) tick();
                check("no_early_swap_cnt", int'(bus.frame_cnt), prev_cnt);
                check("busy_before_last_beat", int'(bus.busy), 1);
            end
            bus.fft_dv       = 1'b1;
            bus.fft_xk_index = LOG2_N'(k);
            bus.fft_xk_re    = bre[k];
            bus.fft_xk_im    = bim[k];
            tick();
        end
        bus.fft_dv    = 1'b0;
        bus.fft_xk_re = '0;
        bus.fft_xk_im = '0;
    endtask

    task automatic wait_frame(input int exp_cnt);
        int n;
        n = 0;
        while (!bus.frame_ready && n < 20) begin
            tick();
            n++;
        end
        check("frame_ready_seen", int'(bus.frame_ready), 1);
        check("frame_cnt", int'(bus.frame_cnt), exp_cnt);
        tick();
    endtask

    initial begin
        int rd0;
        int s0;
        int n;
        bus.fifo_count   = '0;
        bus.fft_dv       = 1'b0;
        bus.fft_xk_index = '0;
        bus.fft_xk_re    = '0;
        bus.fft_xk_im    = '0;
        bus.disp_addr    = '0;
        bus.peak_en      = 1'b0;
        clear_bins();

        // Reset state and CLEAR duration
        reset = 1'b1;
        repeat (3) tick();
        check("rst_busy", int'(bus.busy), 1);
        check("rst_fifo_rd_en", int'(bus.fifo_rd_en), 0);
        check("rst_fft_start", int'(bus.fft_start), 0);
        check("rst_xn_valid", int'(bus.fft_xn_valid), 0);
        check("rst_xn_re", int'(bus.fft_xn_re), 0);
        check("rst_frame_ready", int'(bus.frame_ready), 0);
        check("rst_frame_cnt", int'(bus.frame_cnt), 0);
        check("rst_disp_data", int'(bus.disp_data), 0);
        reset = 1'b0;
        wait_clear();
        read_all();

        // Fill threshold: 511 must not start a frame
        bus.fifo_count = FIFO_CNT_W'(N - 1);
        s0 = start_cnt;
        repeat (20) tick();
        check("no_start_at_511", start_cnt - s0, 0);
        check("idle_busy", int'(bus.busy), 0);

        // Frame 1: plain magnitudes, including saturation at bin 7
        start_frame(rd0);
        wait_load(rd0);
        clear_bins();
        bre[3] = 8'sd12;   bim[3] = 8'sd5;     exp_disp[3] = 8'd10;
        bre[7] = -8'sd128; bim[7] = -8'sd128;  exp_disp[7] = 8'd255;
        fr_q.push_back(16'd1);
        send_beats(1'b0, 0);
        wait_frame(1);
        read_all();

        // Frame A: peak mode; stray dv in WAIT_FILL and LOAD must be ignored
        bus.peak_en = 1'b1;
        pulse_dv(9, 100, 100);
        start_frame(rd0);
        pulse_dv(5, 50, 50);
        wait_load(rd0);
        clear_bins();
        bre[3] = 8'sd56; bim[3] = 8'sd8; exp_disp[3] = 8'd200;
        exp_disp[7] = 8'd254;
        fr_q.push_back(16'd2);
        send_beats(1'b1, 1);
        wait_frame(2);
        read_all();

        // Frame B: all-zero input decays held peaks by one
        start_frame(rd0);
        wait_load(rd0);
        clear_bins();
        exp_disp[3] = 8'd199;
        exp_disp[7] = 8'd253;
        fr_q.push_back(16'd3);
        send_beats(1'b0, 2);
        wait_frame(3);
        read_all();

        // Frame C: peak_en dropped mid-frame still decays this frame
        start_frame(rd0);
        bus.peak_en = 1'b0;
        wait_load(rd0);
        clear_bins();
        exp_disp[3] = 8'd198;
        exp_disp[7] = 8'd252;
        fr_q.push_back(16'd4);
        send_beats(1'b0, 3);
        wait_frame(4);
        read_all();

        // Frame D: peak off; signed inputs and saturation edges
        start_frame(rd0);
        wait_load(rd0);
        clear_bins();
        bre[100] = -8'sd3;   bim[100] = 8'sd4;    exp_disp[100] = 8'd1;
        bre[201] = 8'sd63;   bim[201] = 8'sd11;   exp_disp[201] = 8'd255;
        bre[202] = -8'sd64;  bim[202] = 8'sd0;    exp_disp[202] = 8'd255;
        bre[203] = -8'sd128; bim[203] = 8'sd127;  exp_disp[203] = 8'd255;
        bre[204] = 8'sd0;    bim[204] = -8'sd1;   exp_disp[204] = 8'd0;
        bre[205] = 8'sd60;   bim[205] = 8'sd10;   exp_disp[205] = 8'd231;
        fr_q.push_back(16'd5);
        send_beats(1'b0, 4);
        wait_frame(5);
        read_all();

        // Reset in the middle of LOAD at sample 100
        start_frame(rd0);
        n = 0;
        while ((rd_total - rd0) < 100 && n < 200) begin
            tick();
            n++;
        end
        check("abort_at_sample", rd_total - rd0, 100);
        reset = 1'b1;
        tick();
        check("abort_rd_en", int'(bus.fifo_rd_en), 0);
        check("abort_busy", int'(bus.busy), 1);
        check("abort_frame_cnt", int'(bus.frame_cnt), 0);
        xn_q.delete();
        reset = 1'b0;
        wait_clear();
        clear_bins();
        read_all();
        check("final_frame_cnt", int'(bus.frame_cnt), 0);

        check("xn_q_drained", xn_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        check("fr_q_drained", fr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
